// File: rtl/fpu_core_sched_pkg.sv
// Shared types for the FPU core scheduler: FSM state encoding, status width,
// and the latched response record.
package fpu_core_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int STATUS_W  = 5;

    // Response fields sized for the largest supported configuration
    // (NUM_REQ up to 8, results up to 256 bits); the top uses the low bits.
    localparam int RSP_ID_W  = 3;
    localparam int RSP_RES_W = 256;

    typedef struct packed {
        logic [RSP_ID_W-1:0]  id;
        logic [RSP_RES_W-1:0] result;
        logic [STATUS_W-1:0]  status;
        logic                 err;
    } rsp_t;

endpackage

// File: rtl/fpu_core_sched_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module fpu_core_sched_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int               c;
        logic [IDX_W-1:0] sel;
        c   = 0;
        sel = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            sel = IDX_W'(c);
            if (!any && req[sel]) begin
                gnt[sel] = 1'b1;
                idx      = sel;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_core_sched.sv
// Shares one FPU core among NUM_REQ requesters (IDLE -> BUSY -> RESP).
// Optional busy watchdog enabled by defining FPU_CORE_SCHED_WDOG_EN.
module fpu_core_sched
    import fpu_core_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 212,
    parameter int RES_W   = 64,
    parameter int TIMEOUT = 127
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic                        flush_i,
    output logic                        core_enable_o,
    output logic [DATA_W-1:0]           core_data_o,
    input  logic                        core_ready_i,
    input  logic [RES_W-1:0]            core_result_i,
    input  logic [4:0]                  core_status_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
    output logic [RES_W-1:0]            rsp_result_o,
    output logic [4:0]                  rsp_status_o,
    output logic                        rsp_err_o,
    output logic                        busy_o
);

    // state | meaning
    // IDLE  | waiting for any req_valid_i; grants in the same cycle
    // BUSY  | core enabled with latched payload; waiting for core_ready_i edge
    // RESP  | response held until rsp_ready_i (or flush)

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_q;
    logic                ready_q;
    logic [DATA_W-1:0]   data_q;
    rsp_t                rsp_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                grant;
    logic                complete;
    logic                timeout;

    fpu_core_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req (req_valid_i),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign grant    = (state_q == IDLE) && arb_any && !flush_i && !rst_i;
    // ready_q resets high so a level already up at reset is not an edge.
    assign complete = (state_q == BUSY) && core_ready_i && !ready_q;

`ifdef FPU_CORE_SCHED_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (grant) begin
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout   = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign rsp_err_o = rsp_q.err;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (complete || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = grant ? arb_gnt : '0;
        core_enable_o = (state_q == BUSY);
        rsp_valid_o   = (state_q == RESP);
        busy_o        = (state_q != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            ready_q <= 1'b1;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            ready_q <= core_ready_i;
            if (grant) begin
                rr_q                <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                data_q              <= req_data_i[arb_idx*DATA_W +: DATA_W];
                rsp_q.id            <= '0;
                rsp_q.id[IDX_W-1:0] <= arb_idx;
            end
            if ((state_q == BUSY) && !flush_i) begin
                if (complete) begin
                    rsp_q.result              <= '0;
                    rsp_q.result[RES_W-1:0]   <= core_result_i;
                    rsp_q.status              <= core_status_i;
                    rsp_q.err                 <= 1'b0;
                end else if (timeout) begin
                    rsp_q.result <= '0;
                    rsp_q.status <= '0;
                    rsp_q.err    <= 1'b1;
                end
            end
        end
    end

    assign core_data_o  = data_q;
    assign rsp_id_o     = rsp_q.id[IDX_W-1:0];
    assign rsp_result_o = rsp_q.result[RES_W-1:0];
    assign rsp_status_o = rsp_q.status;

    logic unused_rsp;
    assign unused_rsp = ^{rsp_q.id, rsp_q.result, rsp_q.err};

endmodule

// File: tb/tb_fpu_core_sched.sv
// Directed bench for fpu_core_sched (NUM_REQ=2, TIMEOUT=20); the timeout
// scenario runs when FPU_CORE_SCHED_WDOG_EN is defined.
module tb_fpu_core_sched;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 212;
    localparam int RES_W   = 64;

    localparam logic [DATA_W-1:0] D0 = {53{4'hA}};
    localparam logic [DATA_W-1:0] D1 = {53{4'h5}};

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [NUM_REQ*DATA_W-1:0]  req_data_i;
    logic                       flush_i;
    logic                       core_enable_o;
    logic [DATA_W-1:0]          core_data_o;
    logic                       core_ready_i;
    logic [RES_W-1:0]           core_result_i;
    logic [4:0]                 core_status_i;
    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic [0:0]                 rsp_id_o;
    logic [RES_W-1:0]           rsp_result_o;
    logic [4:0]                 rsp_status_o;
    logic                       rsp_err_o;
    logic                       busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    fpu_core_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W),
        .TIMEOUT (20)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_data_i    (req_data_i),
        .flush_i       (flush_i),
        .core_enable_o (core_enable_o),
        .core_data_o   (core_data_o),
        .core_ready_i  (core_ready_i),
        .core_result_i (core_result_i),
        .core_status_i (core_status_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_result_o  (rsp_result_o),
        .rsp_status_o  (rsp_status_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [RES_W-1:0] r;
        int               exp_id;

        rst_i         = 1'b1;
        req_valid_i   = '0;
        req_data_i    = {D1, D0};
        flush_i       = 1'b0;
        core_ready_i  = 1'b1;
        core_result_i = '0;
        core_status_i = '0;
        rsp_ready_i   = 1'b0;

        // Reset state, with core_ready_i already high
        repeat (3) cyc();
        smp();
        check("rst_busy",      busy_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_core_en",   core_enable_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_err",   rsp_err_o, 0);
        check("rst_rsp_id",    rsp_id_o, 0);
        check("rst_rsp_res",   rsp_result_o, 0);
        check("rst_rsp_stat",  rsp_status_o, 0);
        check("rst_core_data", core_data_o, 0);

        // Stale high core_ready_i must not complete the first operation
        cyc(); rst_i = 1'b0; req_valid_i = 2'b01; smp();
        check("stale_grant", req_ready_o, 2'b01);
        cyc(); req_valid_i = 2'b00; smp();
        check("stale_core_en",   core_enable_o, 1);
        check("stale_core_data", core_data_o, D0);
        repeat (3) begin
            cyc(); smp();
            check("stale_no_rsp", rsp_valid_o, 0);
        end
        cyc(); core_ready_i = 1'b0; smp();
        cyc(); core_ready_i = 1'b1; core_result_i = 64'h1111_2222_3333_4444; core_status_i = 5'h11; smp();
        check("stale_still_en", core_enable_o, 1);
        cyc(); smp();
        check("stale_rsp_valid", rsp_valid_o, 1);
        check("stale_core_off",  core_enable_o, 0);
        check("stale_rsp_id",    rsp_id_o, 0);
        check("stale_rsp_res",   rsp_result_o, 64'h1111_2222_3333_4444);
        check("stale_rsp_stat",  rsp_status_o, 5'h11);
        cyc(); rsp_ready_i = 1'b1; smp();
        cyc(); rsp_ready_i = 1'b0; core_ready_i = 1'b0; smp();
        check("stale_idle", busy_o, 0);

        // Single request from requester 1, core done 5 cycles after enable
        cyc(); req_valid_i = 2'b10; smp();
        check("single_grant", req_ready_o, 2'b10);
        cyc(); req_valid_i = 2'b00; smp();
        check("single_core_en",   core_enable_o, 1);
        check("single_core_data", core_data_o, D1);
        repeat (4) begin
            cyc(); smp();
            check("single_wait_en",  core_enable_o, 1);
            check("single_wait_rsp", rsp_valid_o, 0);
        end
        cyc(); core_ready_i = 1'b1; core_result_i = 64'hDEAD_BEEF_0000_0005; core_status_i = 5'h05; smp();
        cyc(); smp();
        check("single_rsp_valid", rsp_valid_o, 1);
        check("single_core_off",  core_enable_o, 0);
        check("single_rsp_id",    rsp_id_o, 1);
        check("single_rsp_res",   rsp_result_o, 64'hDEAD_BEEF_0000_0005);
        check("single_rsp_stat",  rsp_status_o, 5'h05);

        // Response back-pressure: fields stable, no grant while RESP
        cyc(); req_valid_i = 2'b11; core_ready_i = 1'b0; core_result_i = 64'h0BAD; core_status_i = 5'h1F; smp();
        repeat (10) begin
            cyc(); smp();
            check("hold_rsp_valid", rsp_valid_o, 1);
            check("hold_rsp_res",   rsp_result_o, 64'hDEAD_BEEF_0000_0005);
            check("hold_rsp_stat",  rsp_status_o, 5'h05);
            check("hold_rsp_id",    rsp_id_o, 1);
            check("hold_no_grant",  req_ready_o, 2'b00);
        end
        cyc(); rsp_ready_i = 1'b1; smp();
        cyc(); rsp_ready_i = 1'b0; smp();

        // Both requesters continuously valid: grants alternate 0,1,0,1
        exp_id = 0;
        for (int i = 0; i < 4; i++) begin
            r = 64'h100 + 64'(i);
            check("alt_grant", req_ready_o, (exp_id == 0) ? 2'b01 : 2'b10);
            check("alt_idle",  busy_o, 0);
            cyc(); smp();
            check("alt_core_en",   core_enable_o, 1);
            check("alt_core_data", core_data_o, (exp_id == 0) ? D0 : D1);
            cyc(); core_ready_i = 1'b1; core_result_i = r; core_status_i = 5'(i); smp();
            cyc(); core_ready_i = 1'b0; rsp_ready_i = 1'b1; smp();
            check("alt_rsp_valid", rsp_valid_o, 1);
            check("alt_rsp_id",    rsp_id_o, exp_id);
            check("alt_rsp_res",   rsp_result_o, r);
            cyc(); rsp_ready_i = 1'b0; req_valid_i = (i == 3) ? 2'b00 : 2'b11; smp();
            exp_id = 1 - exp_id;
        end
        check("alt_end_idle", req_ready_o, 2'b00);

        // Flush in BUSY cycle 3, then an immediate grant from IDLE
        cyc(); req_valid_i = 2'b10; smp();
        check("flush_grant", req_ready_o, 2'b10);
        cyc(); req_valid_i = 2'b00; smp();
        cyc(); smp();
        cyc(); flush_i = 1'b1; smp();
        check("flush_busy_en", core_enable_o, 1);
        cyc(); flush_i = 1'b0; req_valid_i = 2'b01; smp();
        check("flush_core_off", core_enable_o, 0);
        check("flush_idle",     busy_o, 0);
        check("flush_no_rsp",   rsp_valid_o, 0);
        check("flush_regrant",  req_ready_o, 2'b01);
        cyc(); req_valid_i = 2'b00; smp();
        check("flush_core_data", core_data_o, D0);
        cyc(); core_ready_i = 1'b1; core_result_i = 64'h77; core_status_i = 5'h02; smp();
        cyc(); core_ready_i = 1'b0; smp();
        check("flush_resp", rsp_valid_o, 1);

        // Flush in RESP drops the response; flush in IDLE suppresses the grant
        cyc(); flush_i = 1'b1; smp();
        cyc(); req_valid_i = 2'b01; smp();
        check("rflush_no_rsp",    rsp_valid_o, 0);
        check("rflush_idle",      busy_o, 0);
        check("iflush_suppress",  req_ready_o, 2'b00);
        cyc(); flush_i = 1'b0; smp();
        check("iflush_grant", req_ready_o, 2'b01);
        cyc(); req_valid_i = 2'b00; core_result_i = 64'hFFFF; core_status_i = 5'h1F; smp();
        check("last_busy", busy_o, 1);

`ifdef FPU_CORE_SCHED_WDOG_EN
        // Core never ready: watchdog fires after 20 BUSY cycles
        repeat (19) begin
            cyc(); smp();
        end
        check("wdog_busy20_en",  core_enable_o, 1);
        check("wdog_busy20_rsp", rsp_valid_o, 0);
        cyc(); smp();
        check("wdog_rsp_valid", rsp_valid_o, 1);
        check("wdog_rsp_err",   rsp_err_o, 1);
        check("wdog_rsp_res",   rsp_result_o, 0);
        check("wdog_rsp_stat",  rsp_status_o, 0);
        check("wdog_core_off",  core_enable_o, 0);
`else
        // Without the watchdog BUSY waits indefinitely
        repeat (30) begin
            cyc(); smp();
        end
        check("nowdog_still_en", core_enable_o, 1);
        check("nowdog_no_rsp",   rsp_valid_o, 0);
        cyc(); core_ready_i = 1'b1; smp();
        cyc(); core_ready_i = 1'b0; smp();
        check("nowdog_rsp_valid", rsp_valid_o, 1);
        check("nowdog_rsp_err",   rsp_err_o, 0);
        check("nowdog_rsp_res",   rsp_result_o, 64'hFFFF);
`endif
        cyc(); rsp_ready_i = 1'b1; smp();
        cyc(); rsp_ready_i = 1'b0; smp();
        check("final_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_core_sched.md
FPU_CORE_SCHED -- requirements
Module: fpu_core_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one FPU core (2..8).
REQ-002 SHALL have parameter DATA_W, default 212, opaque request payload width (operands, formats, rounding mode, op).
REQ-003 SHALL have parameter RES_W, default 64, core result width.
REQ-004 SHALL have parameter TIMEOUT, default 127, watchdog limit in cycles (used only with FPU_CORE_SCHED_WDOG_EN).
REQ-005 SHALL have port clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready_o  out  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-009 SHALL have port req_data_i  in  NUM_REQ x DATA_W  per-requester payload.
REQ-010 SHALL have port flush_i  in  1  abandon in-flight operation.
REQ-011 SHALL have port core_enable_o  out  1  level enable to the FPU core.
REQ-012 SHALL have port core_data_o  out  DATA_W  latched payload driven to the core.
REQ-013 SHALL have port core_ready_i  in  1  core done level; completion is its rising edge.
REQ-014 SHALL have port core_result_i  in  RES_W  core result; core_status_i  in  5  NV/DZ/OF/UF/NX.
REQ-015 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_id_o out clog2(NUM_REQ), rsp_result_o out RES_W, rsp_status_o out 5, rsp_err_o out 1.
REQ-016 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-018 IDLE: if any req_valid_i, SHALL grant round-robin starting at pointer rr_q, assert req_ready_o[winner] that same cycle, latch payload and winner id, enter BUSY next cycle.
REQ-019 SHALL advance rr_q to (winner+1) mod NUM_REQ on each grant; rr_q unchanged when idle.
REQ-020 BUSY: SHALL hold core_enable_o=1 and core_data_o stable; ready_q SHALL register core_ready_i every cycle.
REQ-021 Completion SHALL be core_ready_i=1 && ready_q=0 while in BUSY; SHALL latch result/status, drop core_enable_o, enter RESP.
REQ-022 RESP: SHALL hold rsp_valid_o=1 and response fields stable until rsp_ready_i=1, then enter IDLE.
REQ-023 Minimum grant-to-grant spacing SHALL be completion latency + 2 cycles; no grant in BUSY or RESP.
REQ-024 flush_i in BUSY SHALL drop core_enable_o next cycle and return to IDLE with no response; in RESP SHALL drop the pending response; in IDLE SHALL suppress that cycle's grant.
REQ-025 A completion edge arriving in IDLE or RESP SHALL be ignored.
REQ-026 Requester holding req_valid_i without grant SHALL be served within NUM_REQ grants.

Reset
REQ-027 On rst_i: state=IDLE, rr_q=0, ready_q=1, core_enable_o=0, req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0, latched data/result/status/id=0.
REQ-028 Reset mid-operation SHALL abandon BUSY/RESP without response; ready_q=1 prevents a stale high core_ready_i being taken as completion.

Configuration
REQ-029 With FPU_CORE_SCHED_WDOG_EN defined, a counter SHALL clear on BUSY entry, increment per BUSY cycle, and on reaching TIMEOUT SHALL drop core_enable_o and enter RESP with rsp_err_o=1, rsp_result_o=0, rsp_status_o=0.
REQ-030 Without FPU_CORE_SCHED_WDOG_EN, no counter SHALL exist, BUSY SHALL wait indefinitely, rsp_err_o SHALL be tied 0.

Structure
REQ-031 Package fpu_core_sched_pkg SHALL hold state enum (IDLE, BUSY, RESP), status width constant 5, response struct {id, result, status, err}.
REQ-032 Round-robin selection SHALL be sub-module fpu_core_sched_rr_arb (inputs req vector, pointer; outputs one-hot grant, index, any).

Verification
REQ-033 NUM_REQ=2, req_valid_i=2'b11 continuously after reset -> grants alternate 0,1,0,1; rsp_id_o sequence matches.
REQ-034 Single request, core_ready_i rises 5 cycles after enable -> rsp_valid_o 1 cycle later, result/status equal core values, core_enable_o low.
REQ-035 rsp_ready_i held low 10 cycles -> rsp_valid_o and fields stable, no new grant, req_ready_o=0.
REQ-036 flush_i pulse at BUSY cycle 3 -> core_enable_o=0 next cycle, no rsp_valid_o, next request granted from IDLE.
REQ-037 core_ready_i held high across reset and into first BUSY -> no completion until it falls and rises again.
REQ-038 With FPU_CORE_SCHED_WDOG_EN, TIMEOUT=20, core never ready -> rsp_valid_o with rsp_err_o=1 after 20 BUSY cycles.
